axi4_lite_arbiter: RTL
======================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of all AW/AR channels.
REQ-002 Parameter DATA_WIDTH, default 32: data width of W/R channels; strobe width is DATA_WIDTH/8.
REQ-003 aclk  input  1  single clock; all logic rising-edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 mN_awaddr/mN_awprot/mN_awvalid  input  ADDR_WIDTH/3/1  write address from master N (N=0,1).
REQ-006 mN_awready  output  1  write address accepted for master N.
REQ-007 mN_wdata/mN_wstrb/mN_wvalid  input  DATA_WIDTH/DATA_WIDTH/8/1  write data from master N.
REQ-008 mN_wready  output  1  write data accepted for master N.
REQ-009 mN_bresp/mN_bvalid  output  2/1  write response to master N; mN_bready  input  1.
REQ-010 mN_araddr/mN_arprot/mN_arvalid  input  ADDR_WIDTH/3/1  read address from master N; mN_arready  output  1.
REQ-011 mN_rdata/mN_rresp/mN_rvalid  output  DATA_WIDTH/2/1  read data to master N; mN_rready  input  1.
REQ-012 s_awaddr/s_awprot/s_awvalid  output, s_awready  input: slave write address channel.
REQ-013 s_wdata/s_wstrb/s_wvalid  output, s_wready  input: slave write data channel.
REQ-014 s_bresp/s_bvalid  input, s_bready  output: slave write response channel.
REQ-015 s_araddr/s_arprot/s_arvalid  output, s_arready  input: slave read address channel.
REQ-016 s_rdata/s_rresp/s_rvalid  input, s_rready  output: slave read data channel.

Function
REQ-017 Write and read paths SHALL arbitrate independently; one write and one read may be in flight simultaneously, possibly for different masters.
REQ-018 Write FSM states W_IDLE, W_ADDR, W_RESP; read FSM states R_IDLE, R_ADDR, R_DATA.
REQ-019 W_IDLE: if any mN_awvalid=1, register grant and go to W_ADDR next cycle (1-cycle arbitration latency); else stay.
REQ-020 Write request = mN_awvalid only; mN_wvalid SHALL NOT trigger arbitration.
REQ-021 Both requesting: grant the master not granted last (round-robin, separate pointers for write and read); one requesting: grant it.
REQ-022 W_ADDR: granted master's AW and W SHALL be forwarded combinationally to the slave; readys returned only to granted master.
REQ-023 aw_done/w_done flags SHALL record each handshake; s_awvalid forced 0 after aw_done, s_wvalid forced 0 after w_done; AW and W may complete in either order or the same cycle.
REQ-024 W_ADDR -> W_RESP when both handshakes complete; flags clear on exit.
REQ-025 W_RESP: s_bresp/s_bvalid routed to granted master, s_bready = granted mN_bready; on s_bvalid&s_bready -> W_IDLE and update write pointer.
REQ-026 Read: R_IDLE arbitrates on mN_arvalid as REQ-019/021; R_ADDR forwards AR until s_arvalid&s_arready -> R_DATA; R_DATA forwards R until s_rvalid&s_rready -> R_IDLE and update read pointer.
REQ-027 Non-granted master SHALL see awready, wready, bvalid, arready, rvalid all 0; s_*valid and s_*ready outputs 0 in idle states.
REQ-028 Forwarded payload (addr, prot, data, strb, resp) SHALL be zero when its valid is 0.
REQ-029 A master dropping valid before handshake is a protocol violation; behaviour unspecified.

Reset
REQ-030 aresetn=0 SHALL immediately force both FSMs to idle, clear aw_done/w_done, and drive every valid/ready output 0.
REQ-031 Both round-robin pointers reset to "master 1 last", so master 0 wins the first contention.
REQ-032 Reset mid-transaction SHALL abandon it; no response is delivered after reset release.

Verification
REQ-033 Single write: m0 AW 0x10, W 0xDEADBEEF, strb 0xF -> slave sees exactly one AW and one W, bresp OKAY reaches m0 only, m1_bvalid stays 0.
REQ-034 Contention: m0 and m1 awvalid same cycle after reset -> m0 served first, m1 next; repeat -> order alternates m1, m0.
REQ-035 W before AW: m0_wvalid 2 cycles before awvalid, slave s_awready delayed 3 cycles -> single s_wvalid pulse, FSM reaches W_RESP only after both.
REQ-036 Concurrent: m0 write 0x20 and m1 read 0x30 simultaneously -> both complete, rdata 0x12345678 to m1 only, bresp to m0 only.
REQ-037 Backpressure: s_bvalid held while m0_bready=0 for 4 cycles -> FSM stays W_RESP, no new grant until handshake.
REQ-038 Reset in R_DATA: aresetn low for 1 cycle -> all valids 0, m1_rvalid never asserts, next read arbitrates normally.

Source files
------------

// File: rtl/axi4_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter.
// Write and read paths arbitrate independently, round-robin per path.
module axi4_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic [2:0]              m0_awprot,
  input  logic                    m0_awvalid,
  output logic                    m0_awready,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                    m0_wvalid,
  output logic                    m0_wready,
  output logic [1:0]              m0_bresp,
  output logic                    m0_bvalid,
  input  logic                    m0_bready,
  input  logic [ADDR_WIDTH-1:0]   m0_araddr,
  input  logic [2:0]              m0_arprot,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [1:0]              m0_rresp,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic [2:0]              m1_awprot,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [1:0]              m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  input  logic [ADDR_WIDTH-1:0]   m1_araddr,
  input  logic [2:0]              m1_arprot,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [1:0]              m1_rresp,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic [2:0]              s_awprot,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic [2:0]              s_arprot,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

  w_state_t r_wstate, w_wnext;
  r_state_t r_rstate, w_rnext;

  logic r_wgnt, r_wlast;
  logic r_rgnt, r_rlast;
  logic r_aw_done, r_w_done;

  logic w_wreq, w_wpick, w_rreq, w_rpick;
  logic w_aw_hs, w_w_hs, w_b_hs, w_wadv;
  logic w_ar_hs, w_r_hs;

  // Contention goes to the master not served last.
  assign w_wreq  = m0_awvalid | m1_awvalid;
  assign w_wpick = (m0_awvalid & m1_awvalid) ? ~r_wlast : m1_awvalid;
  assign w_rreq  = m0_arvalid | m1_arvalid;
  assign w_rpick = (m0_arvalid & m1_arvalid) ? ~r_rlast : m1_arvalid;

  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid & s_wready;
  assign w_b_hs  = (r_wstate == W_RESP) & s_bvalid & s_bready;
  assign w_wadv  = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_ar_hs = s_arvalid & s_arready;
  assign w_r_hs  = (r_rstate == R_DATA) & s_rvalid & s_rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_wgnt    <= 1'b0;
      r_wlast   <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_wstate <= w_wnext;
      if (r_wstate == W_IDLE && w_wreq)
        r_wgnt <= w_wpick;
      if (r_wstate == W_ADDR) begin
        if (w_wadv) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          r_aw_done <= r_aw_done | w_aw_hs;
          r_w_done  <= r_w_done | w_w_hs;
        end
      end
      if (w_b_hs)
        r_wlast <= r_wgnt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      r_rgnt   <= 1'b0;
      r_rlast  <= 1'b1;
    end else begin
      r_rstate <= w_rnext;
      if (r_rstate == R_IDLE && w_rreq)
        r_rgnt <= w_rpick;
      if (w_r_hs)
        r_rlast <= r_rgnt;
    end
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wreq) w_wnext = W_ADDR;
      W_ADDR:  if (w_wadv) w_wnext = W_RESP;
      W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_rreq) w_rnext = R_ADDR;
      R_ADDR:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_r_hs) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Write channel routing; payloads stay zero unless their valid is high.
  always_comb begin
    s_awaddr   = '0;
    s_awprot   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bresp   = '0;
    m1_bresp   = '0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    if (r_wstate == W_ADDR) begin
      s_awvalid = ~r_aw_done & (r_wgnt ? m1_awvalid : m0_awvalid);
      s_wvalid  = ~r_w_done & (r_wgnt ? m1_wvalid : m0_wvalid);
      if (s_awvalid) begin
        s_awaddr = r_wgnt ? m1_awaddr : m0_awaddr;
        s_awprot = r_wgnt ? m1_awprot : m0_awprot;
      end
      if (s_wvalid) begin
        s_wdata = r_wgnt ? m1_wdata : m0_wdata;
        s_wstrb = r_wgnt ? m1_wstrb : m0_wstrb;
      end
      m0_awready = ~r_wgnt & ~r_aw_done & s_awready;
      m1_awready = r_wgnt & ~r_aw_done & s_awready;
      m0_wready  = ~r_wgnt & ~r_w_done & s_wready;
      m1_wready  = r_wgnt & ~r_w_done & s_wready;
    end
    if (r_wstate == W_RESP) begin
      s_bready  = r_wgnt ? m1_bready : m0_bready;
      m0_bvalid = ~r_wgnt & s_bvalid;
      m1_bvalid = r_wgnt & s_bvalid;
      if (m0_bvalid) m0_bresp = s_bresp;
      if (m1_bvalid) m1_bresp = s_bresp;
    end
  end

  always_comb begin
    s_araddr   = '0;
    s_arprot   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = '0;
    m1_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    if (r_rstate == R_ADDR) begin
      s_arvalid = r_rgnt ? m1_arvalid : m0_arvalid;
      if (s_arvalid) begin
        s_araddr = r_rgnt ? m1_araddr : m0_araddr;
        s_arprot = r_rgnt ? m1_arprot : m0_arprot;
      end
      m0_arready = ~r_rgnt & s_arready;
      m1_arready = r_rgnt & s_arready;
    end
    if (r_rstate == R_DATA) begin
      s_rready  = r_rgnt ? m1_rready : m0_rready;
      m0_rvalid = ~r_rgnt & s_rvalid;
      m1_rvalid = r_rgnt & s_rvalid;
      if (m0_rvalid) begin
        m0_rdata = s_rdata;
        m0_rresp = s_rresp;
      end
      if (m1_rvalid) begin
        m1_rdata = s_rdata;
        m1_rresp = s_rresp;
      end
    end
  end

endmodule
